// File: rtl/arb_4_32_pkg.sv
// Shared sizing, state encoding and index helper for the 4-source round-robin arbiter.
package arb_4_32_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;

    // Grants are always one-hot, so OR-ing the indices of set bits is exact.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick_4.sv
// Combinational rotating priority pick: first set candidate at ptr, ptr+1, ... wrapping.
module arb_rr_pick_4
    import arb_4_32_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_cand,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_hit,
    output logic [SEL_W-1:0]   o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);

    logic [NUM_REQ-1:0] w_rot;
    logic [SEL_W-1:0]   w_off;

    // w_rot[k] is the candidate k places after the pointer; the 2-bit add wraps 3->0.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rot
        localparam logic [SEL_W-1:0] K = SEL_W'(k);
        assign w_rot[k] = i_cand[i_ptr + K];
    end

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = SEL_W'(k);
        end
    end

    assign o_hit    = |w_rot;
    assign o_idx    = i_ptr + w_off;
    assign o_onehot = o_hit ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/arb_4_32_rr.sv
// Round-robin arbiter driving select/enable of the 4:1 x 32-bit bus mux, with grant watchdog.
// Define ARB_4_32_RR_LOCK_EN to add the i_lock port (winner may keep its grant across transfers).
module arb_4_32_rr
    import arb_4_32_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0]   o_select,
    output logic               o_enable,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_timeout_err
`ifdef ARB_4_32_RR_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0] i_lock
`endif
);

    localparam bit WD_ON = (TIMEOUT > 0);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = WD_ON ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_wdog;
    logic               r_tmo;

    logic               w_grant;
    logic               w_xfer;
    logic               w_tmo;
    logic               w_hold;
    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_win_nx;
    logic [NUM_REQ-1:0] w_cand;
    logic [SEL_W-1:0]   w_pptr;
    logic               w_hit;
    logic [SEL_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_onehot;

    assign w_grant  = (r_state == ST_GRANT);
    assign w_xfer   = w_grant & i_out_ready;
    assign w_win    = onehot_to_idx(r_gnt);
    assign w_win_nx = w_win + SEL_W'(1);
    assign w_tmo    = WD_ON && w_grant && !w_xfer && (r_wdog == WD_LAST);

`ifdef ARB_4_32_RR_LOCK_EN
    assign w_hold = w_xfer & i_lock[w_win] & i_req[w_win];
`else
    assign w_hold = 1'b0;
`endif

    // After a transfer the re-pick excludes the current winner and starts just past it,
    // so a back-to-back handover needs no idle cycle.
    assign w_cand = w_grant ? (i_req & ~r_gnt) : i_req;
    assign w_pptr = w_grant ? w_win_nx : r_ptr;

    arb_rr_pick_4 u_pick (
        .i_cand   (w_cand),
        .i_ptr    (w_pptr),
        .o_hit    (w_hit),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_wdog  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            if (!w_grant) begin
                if (w_hit) begin
                    r_state <= ST_GRANT;
                    r_gnt   <= w_onehot;
                    r_sel   <= w_idx;
                    r_wdog  <= '0;
                end
            end else if (w_xfer) begin
                if (w_hold) begin
                    r_wdog <= '0;
                end else begin
                    r_ptr  <= w_win_nx;
                    r_wdog <= '0;
                    if (w_hit) begin
                        r_gnt <= w_onehot;
                        r_sel <= w_idx;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
                end
            end else if (w_tmo) begin
                r_state <= ST_IDLE;
                r_gnt   <= '0;
                r_ptr   <= w_win_nx;
                r_wdog  <= '0;
                r_tmo   <= 1'b1;
            end else if (WD_ON) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end
        end
    end

    // select keeps its last value in IDLE; consumers qualify it with enable.
    assign o_gnt         = r_gnt;
    assign o_select      = r_sel;
    assign o_enable      = w_grant;
    assign o_out_valid   = w_grant;
    assign o_timeout_err = r_tmo;

endmodule
